mem_burst_reader: RTL
=====================

Name: mem_burst_reader

Overview:
Read-only DMA client sitting directly upstream of the memory multiplexer, driving one of its slave ports as a mem_interface master. It fetches a programmed run of 16-bit words from 22-bit word addresses in bursts of BURST words and buffers them in an internal FIFO. It presents the words as a valid/ready stream to a consumer such as video scan-out or an audio DMA. Request is dropped between bursts so the multiplexer can rotate to other ports.

Parameters:
BURST, 8, words per request burst; power of two, 4..DEPTH
DEPTH, 16, FIFO depth in words; power of two, at least BURST

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches start_address/length; ignored while busy
start_address  input  22  first word address
length  input  22  number of words to read; 0 = nothing to fetch
abort  input  1  one-cycle pulse; terminates current run and flushes FIFO
busy  output  1  high from accepted start until the last word is popped or abort completes
mem  mem_interface.master  -  port to the multiplexer; uses address[21:0], request, write_enable, last4, data_write[15:0], data_read[15:0], ready
out_data  output  16  head-of-FIFO word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer pop; pop occurs when out_valid && out_ready

Behaviour:
- Reset values: busy=0, out_valid=0, out_data=0, mem.request=0, mem.address=0, mem.last4=0. FIFO is emptied.
- mem.write_enable and mem.data_write are tied to 0.
- Registers: cur_addr (22b), remaining (22b, words not yet requested), burst_left (log2(BURST)+1 bits), FIFO pointers, and count (0..DEPTH).
- FSM states: IDLE, WAIT_SPACE, BURST, GAP.
- IDLE: start with length!=0 loads cur_addr/remaining, sets busy, and goes to WAIT_SPACE. start with length==0 leaves busy at 0 and the state in IDLE.
- WAIT_SPACE: proceeds when DEPTH - count - words_in_flight >= min(BURST, remaining). It then loads burst_left=min(BURST, remaining) and sets request=1 at the next edge. Request therefore rises 1 cycle after start at the earliest.
- BURST: mem.request=1 and mem.address=cur_addr, both registered.
  - On each cycle with mem.ready=1: push data_read into the FIFO in the same edge, increment cur_addr (22-bit wrap 0x3FFFFF->0x000000), and decrement remaining and burst_left.
  - When the last word of the burst is accepted, request falls at that edge and the state goes to GAP.
- mem.last4 = request && burst_left <= 4.
- GAP: request held low for exactly 1 cycle. Next state is WAIT_SPACE if remaining!=0, otherwise IDLE (fetch finished).
- busy clears when the fetch is finished and count==0.
- Read latency: a word accepted on a ready edge appears as out_valid on the following cycle.
- Simultaneous push and pop leaves count unchanged. Push never occurs while full, which is guaranteed by the space check. Pop while empty is ignored.
- abort, any state: at the next edge request=0, the FSM goes to IDLE, the FIFO is flushed, and busy=0. A ready arriving in the abort cycle is discarded. abort together with start: abort wins.
- start while busy: ignored.
- reset mid-burst: request drops at that edge, with no further side effects.

Optional Feature:
MEM_BURST_READER_WRAP_EN
- Defined: when the run completes (remaining reaches 0), cur_addr and remaining reload from the latched start_address/length. Fetching continues indefinitely as a circular scan-out, and busy stays high until abort or reset.
- Not defined: the block stops after a single run as described above.

Test Plan:
1. reset, then start with start_address=0x000100, length=16, out_ready=1, memory returning ready every cycle -> two bursts at 0x100..0x107 and 0x108..0x10F.
   - request low for exactly 1 cycle between bursts.
   - last4 high for the final 4 words of each burst.
   - out_data sequence matches memory; busy falls after the 16th pop.
2. length=20, out_ready=0 -> bursts of 8 and 8, then no request (space 0) until pops free 4+ words; the third burst is 4 words with last4 high throughout.
3. start_address=0x3FFFFE, length=4 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
4. abort on the 3rd ready of a burst -> request low at the next edge, that word not delivered, out_valid=0 and busy=0 the cycle after.
5. start with length=0 -> busy stays 0 and request never rises. start pulsed while busy -> ignored; the run completes with the original parameters.
6. With MEM_BURST_READER_WRAP_EN: start_address=0x40, length=8 -> fetch repeats 0x40..0x47 at least 3 times with busy held high; abort stops it.

Source files
------------

// File: rtl/mem_burst_reader_if.sv
// Memory multiplexer slave-port bundle: 22-bit word address, 16-bit data,
// request/ready handshake with a last4 early-end hint for the arbiter.
interface mem_interface;
    logic [21:0] address;
    logic        request;
    logic        write_enable;
    logic        last4;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        ready;

    modport master (
        output address, request, write_enable, last4, data_write,
        input  data_read, ready
    );

    modport slave (
        input  address, request, write_enable, last4, data_write,
        output data_read, ready
    );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst-reading DMA client: fetches a run of words into a FIFO and streams them out.
// Define MEM_BURST_READER_WRAP_EN to rescan the programmed run endlessly until abort.
module mem_burst_reader #(
    parameter int BURST = 8,
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [21:0] start_address,
    input  logic [21:0] length,
    input  logic        abort,
    output logic        busy,
    mem_interface.master mem,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SPACE, S_BURST, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [21:0]   cur_addr_q, cur_addr_d;
    logic [21:0]   remaining_q, remaining_d;
    logic [BW-1:0] burst_left_q, burst_left_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          request_q, request_d;
    logic          busy_q, busy_d;
`ifdef MEM_BURST_READER_WRAP_EN
    logic [21:0]   run_addr_q, run_addr_d;
    logic [21:0]   run_len_q, run_len_d;
`endif

    logic [15:0]   fifo_mem [DEPTH];
    logic [21:0]   need;
    logic [21:0]   space;
    logic          has_space;
    logic          push;
    logic          pop;
    logic          start_ok;

    // Words are pushed on the accepting edge, so nothing is ever in flight
    // beyond the FIFO count itself.
    always_comb begin
        need      = (remaining_q < 22'(BURST)) ? remaining_q : 22'(BURST);
        space     = 22'(DEPTH) - 22'(count_q);
        has_space = (space >= need);
        start_ok  = start && !busy_q && (state_q == S_IDLE) && (length != 22'd0);
        push      = (state_q == S_BURST) && mem.ready && !abort;
        pop       = (count_q != '0) && out_ready;
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        burst_left_d = burst_left_q;
        request_d    = request_q;
        busy_d       = busy_q;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
`ifdef MEM_BURST_READER_WRAP_EN
        run_addr_d   = run_addr_q;
        run_len_d    = run_len_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    cur_addr_d  = start_address;
                    remaining_d = length;
                    busy_d      = 1'b1;
                    state_d     = S_WAIT_SPACE;
`ifdef MEM_BURST_READER_WRAP_EN
                    run_addr_d  = start_address;
                    run_len_d   = length;
`endif
                end
            end
            // GAP doubles as the space check so request is low for one cycle only.
            S_WAIT_SPACE, S_GAP: begin
                if ((state_q == S_GAP) && (remaining_q == 22'd0)) begin
                    state_d = S_IDLE;
                end else if (has_space) begin
                    burst_left_d = BW'(need);
                    request_d    = 1'b1;
                    state_d      = S_BURST;
                end else begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_BURST: begin
                if (push) begin
                    cur_addr_d   = cur_addr_q + 22'd1;
                    remaining_d  = remaining_q - 22'd1;
                    burst_left_d = burst_left_q - BW'(1);
`ifdef MEM_BURST_READER_WRAP_EN
                    if (remaining_q == 22'd1) begin
                        cur_addr_d  = run_addr_q;
                        remaining_d = run_len_q;
                    end
`endif
                    if (burst_left_q == BW'(1)) begin
                        request_d = 1'b0;
                        state_d   = S_GAP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busy_q && (state_d == S_IDLE) && (count_d == '0)) begin
            busy_d = 1'b0;
        end

        if (abort) begin
            state_d   = S_IDLE;
            request_d = 1'b0;
            busy_d    = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            burst_left_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            request_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MEM_BURST_READER_WRAP_EN
            run_addr_q   <= '0;
            run_len_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            burst_left_q <= burst_left_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            request_q    <= request_d;
            busy_q       <= busy_d;
`ifdef MEM_BURST_READER_WRAP_EN
            run_addr_q   <= run_addr_d;
            run_len_q    <= run_len_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem.data_read;
        end
    end

    assign busy             = busy_q;
    assign out_valid        = (count_q != '0);
    assign out_data         = out_valid ? fifo_mem[rd_ptr_q] : 16'd0;
    assign mem.request      = request_q;
    assign mem.address      = cur_addr_q;
    assign mem.last4        = request_q && (burst_left_q <= BW'(4));
    assign mem.write_enable = 1'b0;
    assign mem.data_write   = 16'd0;
endmodule
